servo_pwm_avmm: RTL

//  Avalon-MM slave peripheral inside soc_system that generates the servo PWM

---
 rtl/servo_pwm_avmm_if.sv | 25 ++
 rtl/servo_pwm_avmm.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/servo_pwm_avmm_if.sv
// Avalon-MM slave bus bundle for the servo PWM peripheral.
// The bus master drives address, strobes and write data; the slave returns read data.
interface servo_pwm_avmm_if;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address,
        output avs_write,
        output avs_writedata,
        output avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address,
        input  avs_write,
        input  avs_writedata,
        input  avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/servo_pwm_avmm.sv
// Servo PWM generator with an Avalon-MM register file. Pulse width writes are clamped
// to the servo-safe range and take effect only at a frame boundary.
module servo_pwm_avmm #(
    parameter int PERIOD_CYCLES = 1000000,
    parameter int MIN_PULSE     = 50000,
    parameter int MAX_PULSE     = 100000,
    parameter int CNT_W         = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    servo_pwm_avmm_if.slave   avs,
    output logic              pwm_out,
    output logic              frame_start
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_P    = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] MID_P    = CNT_W'((MIN_PULSE + MAX_PULSE) / 2);

    // Comparing the full 32-bit word makes any nonzero upper bit count as above MAX.
    function automatic logic out_of_range(input logic [31:0] v);
        return (v < 32'(MIN_PULSE)) || (v > 32'(MAX_PULSE));
    endfunction

    function automatic logic [CNT_W-1:0] clamp_pulse(input logic [31:0] v);
        logic [CNT_W-1:0] r;
        if (v < 32'(MIN_PULSE)) begin
            r = MIN_P;
        end else if (v > 32'(MAX_PULSE)) begin
            r = MAX_P;
        end else begin
            r = v[CNT_W-1:0];
        end
        return r;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ctrl_en_q, ctrl_en_d;
    logic             act_en_q, act_en_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] act_pulse_q, act_pulse_d;
    logic             pending_q, pending_d;
    logic             clamped_q, clamped_d;
    logic             pwm_out_q, pwm_out_d;
    logic             frame_start_q, frame_start_d;
    logic [31:0]      readdata_q, readdata_d;

    logic boundary_s;
    logic wr_ctrl_s;
    logic wr_pulse_s;
    logic wr_status_s;

    // Next-state logic for the frame counter, register file and PWM output.
    always_comb begin
        boundary_s  = (cnt_q == LAST_CNT);
        wr_ctrl_s   = avs.avs_write && (avs.avs_address == 2'd0);
        wr_pulse_s  = avs.avs_write && (avs.avs_address == 2'd1);
        wr_status_s = avs.avs_write && (avs.avs_address == 2'd3);

        if (boundary_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (wr_ctrl_s) begin
            ctrl_en_d = avs.avs_writedata[0];
        end else begin
            ctrl_en_d = ctrl_en_q;
        end

        if (wr_pulse_s) begin
            shadow_d = clamp_pulse(avs.avs_writedata);
        end else begin
            shadow_d = shadow_q;
        end

        if (wr_pulse_s && out_of_range(avs.avs_writedata)) begin
            clamped_d = 1'b1;
        end else if (wr_status_s && avs.avs_writedata[1]) begin
            clamped_d = 1'b0;
        end else begin
            clamped_d = clamped_q;
        end

        // A write landing on the boundary cycle keeps pending set for the next frame.
        if (wr_pulse_s) begin
            pending_d = 1'b1;
        end else if (boundary_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        if (boundary_s) begin
            act_en_d = ctrl_en_q;
        end else begin
            act_en_d = act_en_q;
        end

        if (boundary_s && pending_q) begin
            act_pulse_d = shadow_q;
        end else begin
            act_pulse_d = act_pulse_q;
        end

        pwm_out_d     = act_en_d && (cnt_d < act_pulse_d);
        frame_start_d = boundary_s;

        if (avs.avs_read) begin
            case (avs.avs_address)
                2'd0:    readdata_d = {31'd0, ctrl_en_q};
                2'd1:    readdata_d = {{(32-CNT_W){1'b0}}, shadow_q};
                2'd2:    readdata_d = 32'(PERIOD_CYCLES);
                2'd3:    readdata_d = {29'd0, act_en_q, clamped_q, pending_q};
                default: readdata_d = 32'd0;
            endcase
        end else begin
            readdata_d = 32'd0;
        end
    end

    // State registers; reset forces the output low and restarts a disabled frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= {CNT_W{1'b0}};
            ctrl_en_q     <= 1'b0;
            act_en_q      <= 1'b0;
            shadow_q      <= MID_P;
            act_pulse_q   <= MID_P;
            pending_q     <= 1'b0;
            clamped_q     <= 1'b0;
            pwm_out_q     <= 1'b0;
            frame_start_q <= 1'b0;
            readdata_q    <= 32'd0;
        end else begin
            cnt_q         <= cnt_d;
            ctrl_en_q     <= ctrl_en_d;
            act_en_q      <= act_en_d;
            shadow_q      <= shadow_d;
            act_pulse_q   <= act_pulse_d;
            pending_q     <= pending_d;
            clamped_q     <= clamped_d;
            pwm_out_q     <= pwm_out_d;
            frame_start_q <= frame_start_d;
            readdata_q    <= readdata_d;
        end
    end

    assign pwm_out          = pwm_out_q;
    assign frame_start      = frame_start_q;
    assign avs.avs_readdata = readdata_q;

endmodule
